// File: rtl/vermiram_pkg.sv
// vermiram_pkg: shared FSM state type, wait counter width and index-width helper
//   for the vermiram bus responder and its storage array. No ports.
package vermiram_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACK} vermiram_state_t;
   localparam int WAIT_COUNTER_WIDTH = 4;
   function automatic int index_width(input int size);
      return $clog2(size);
   endfunction
endpackage

// File: rtl/vermiram_array.sv
// vermiram_array: single-port word RAM with four byte lanes, registered read, no reset.
//   clk_i clock; addr_i word index; we_i per-byte write enables;
//   wdata_i write word; rdata_o word at addr_i registered on each edge (old contents on a write).
module vermiram_array
   import vermiram_pkg::*;
#(
   parameter int SIZE = 1024
) (
   input  logic                         clk_i,
   input  logic [index_width(SIZE)-1:0] addr_i,
   input  logic [3:0]                   we_i,
   input  logic [31:0]                  wdata_i,
   output logic [31:0]                  rdata_o
);
   logic [31:0] mem [SIZE];
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++)
         if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      rdata_o <= mem[addr_i];
   end
endmodule

// File: rtl/vermiram.sv
// vermiram: Vermibus responder wrapping a byte-writable word RAM with configurable wait states.
//   clk_i clock; reset_n_i synchronous active-low reset;
//   valid_i/address_i/wstrobe_i/wdata_i request (wstrobe_i==0 is a read);
//   ready_o one-cycle completion pulse; rdata_o read word, zero outside ready_o.
//   With VERMIRAM_STATS_EN defined: read_count_o/write_count_o completed-transaction counters.
module vermiram
   import vermiram_pkg::*;
#(
   parameter int          SIZE         = 1024,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
   parameter int          WAIT_STATES  = 1
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        valid_i,
   input  logic [31:0] address_i,
   input  logic [3:0]  wstrobe_i,
   input  logic [31:0] wdata_i,
`ifdef VERMIRAM_STATS_EN
   output logic [31:0] read_count_o,
   output logic [31:0] write_count_o,
`endif
   output logic        ready_o,
   output logic [31:0] rdata_o
);
   localparam int IW = index_width(SIZE);
   vermiram_state_t               state_q, state_d;
   logic [WAIT_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [3:0]                    strb_q, strb_d;
   logic [31:0]                   wdata_q, wdata_d;
   logic [29:0]                   offset;
   logic                          sel;
   logic [3:0]                    we;
   logic [31:0]                   arr_rdata;
   logic                          unused_addr;
   assign unused_addr = ^address_i[1:0];
   // Unsigned wrap makes addresses below the base fall outside the window too.
   assign offset = address_i[31:2] - BASE_ADDRESS[31:2];
   assign sel    = valid_i && (offset < 30'(SIZE));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: if (sel) begin
            idx_d   = address_i[IW+1:2];
            strb_d  = wstrobe_i;
            wdata_d = wdata_i;
            cnt_d   = WAIT_COUNTER_WIDTH'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? ACK : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = !valid_i ? IDLE : (cnt_q == WAIT_COUNTER_WIDTH'(1)) ? ACK : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         strb_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
      end
   end
   // The array reads idx_d so the word lands in its output register on the edge entering ACK,
   // including the zero-wait path where the index is latched on that same edge.
   // A reset coinciding with the ACK edge suppresses the write.
   assign we = (state_q == ACK && reset_n_i) ? strb_q : 4'b0000;
   vermiram_array #(.SIZE(SIZE)) u_array (
      .clk_i  (clk_i),
      .addr_i (idx_d),
      .we_i   (we),
      .wdata_i(wdata_q),
      .rdata_o(arr_rdata)
   );
   assign ready_o = (state_q == ACK);
   assign rdata_o = ready_o ? arr_rdata : 32'h0;
`ifdef VERMIRAM_STATS_EN
   logic [31:0] read_count_q, write_count_q;
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         read_count_q  <= '0;
         write_count_q <= '0;
      end else if (state_q == ACK) begin
         read_count_q  <= read_count_q + ((strb_q == 4'b0000) ? 32'd1 : 32'd0);
         write_count_q <= write_count_q + ((strb_q != 4'b0000) ? 32'd1 : 32'd0);
      end
   end
   assign read_count_o  = read_count_q;
   assign write_count_o = write_count_q;
`endif
endmodule

// File: tb/tb_vermiram.sv
// tb_vermiram: directed self-checking bench for vermiram over four parameter sets.
//   dut0 WS=1 base 0, dut1 WS=1 base 0x8000_0000, dut2 WS=3 base 0, dut3 WS=0 base 0.
module tb_vermiram;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  valid;
   logic [31:0] address, wdata;
   logic [3:0]  wstrobe;
   logic [3:0]  ready;
   logic [31:0] rdata [4];
`ifdef VERMIRAM_STATS_EN
   logic [31:0] rc [4];
   logic [31:0] wc [4];
`endif
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_dut
      vermiram #(
         .SIZE        (1024),
         .BASE_ADDRESS(g == 1 ? 32'h8000_0000 : 32'h0000_0000),
         .WAIT_STATES (g == 2 ? 3 : g == 3 ? 0 : 1)
      ) u_dut (
         .clk_i        (clk),
         .reset_n_i    (reset_n),
         .valid_i      (valid[g]),
         .address_i    (address),
         .wstrobe_i    (wstrobe),
         .wdata_i      (wdata),
`ifdef VERMIRAM_STATS_EN
         .read_count_o (rc[g]),
         .write_count_o(wc[g]),
`endif
         .ready_o      (ready[g]),
         .rdata_o      (rdata[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic xact(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
      @(negedge clk);
      valid[k] = 1'b1;
      address  = a;
      wstrobe  = s;
      wdata    = d;
      lat      = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready[k] && lat < 50);
      r        = rdata[k];
      valid[k] = 1'b0;
   endtask
   task automatic watch(input int k, input int n, output int hits);
      hits = 0;
      repeat (n) begin
         @(negedge clk);
         if (ready[k]) hits++;
      end
   endtask
   initial begin
      logic [31:0] r;
      int lat, hits;
      reset_n = 1'b0;
      valid   = 4'b0000;
      address = '0;
      wstrobe = '0;
      wdata   = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", {28'h0, ready}, 32'h0);
      check("reset_rdata0", rdata[0], 32'h0);
      check("reset_rdata2", rdata[2], 32'h0);
`ifdef VERMIRAM_STATS_EN
      check("reset_rc", rc[0], 32'h0);
      check("reset_wc", wc[0], 32'h0);
`endif
      reset_n = 1'b1;
      xact(0, 32'h10, 4'hF, 32'hDEAD_BEEF, r, lat);
      check("wr10_lat", 32'(lat), 32'd2);
      xact(0, 32'h10, 4'h0, 32'h0, r, lat);
      check("rd10_lat", 32'(lat), 32'd2);
      check("rd10_data", r, 32'hDEAD_BEEF);
      @(negedge clk);
      check("idle_rdata", rdata[0], 32'h0);
      check("idle_ready", {31'h0, ready[0]}, 32'h0);
      xact(0, 32'h20, 4'hF, 32'h1122_3344, r, lat);
      xact(0, 32'h20, 4'b0101, 32'hAABB_CCDD, r, lat);
      check("strb_old_data", r, 32'h1122_3344);
      xact(0, 32'h23, 4'h0, 32'h0, r, lat);
      check("strb_data", r, 32'h11BB_33DD);
      @(negedge clk);
`ifdef VERMIRAM_STATS_EN
      check("d0_rc", rc[0], 32'd2);
      check("d0_wc", wc[0], 32'd3);
`endif
      valid[1] = 1'b1;
      address  = 32'h8000_1000;
      wstrobe  = 4'hF;
      watch(1, 20, hits);
      check("oow_above", 32'(hits), 32'd0);
      address = 32'h7FFF_FFFC;
      watch(1, 5, hits);
      check("oow_below", 32'(hits), 32'd0);
      valid[1] = 1'b0;
      xact(1, 32'h8000_0FFC, 4'hF, 32'h1234_5678, r, lat);
      check("top_wr_lat", 32'(lat), 32'd2);
      xact(1, 32'h8000_0000, 4'hF, 32'h0A0A_0A0A, r, lat);
      xact(1, 32'h8000_0FFC, 4'h0, 32'h0, r, lat);
      check("top_rd_lat", 32'(lat), 32'd2);
      check("top_rd_data", r, 32'h1234_5678);
      xact(1, 32'h8000_0000, 4'h0, 32'h0, r, lat);
      check("bot_rd_data", r, 32'h0A0A_0A0A);
      xact(2, 32'h40, 4'hF, 32'hCAFE_F00D, r, lat);
      check("ws3_lat", 32'(lat), 32'd4);
      @(negedge clk);
      valid[2] = 1'b1;
      address  = 32'h40;
      wstrobe  = 4'hF;
      wdata    = 32'h0;
      @(negedge clk);
      valid[2] = 1'b0;
      watch(2, 10, hits);
      check("abort_ready", 32'(hits), 32'd0);
      xact(2, 32'h40, 4'h0, 32'h0, r, lat);
      check("abort_data", r, 32'hCAFE_F00D);
      @(negedge clk);
      valid[2] = 1'b1;
      address  = 32'h40;
      wstrobe  = 4'hF;
      wdata    = 32'h0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n  = 1'b1;
      valid[2] = 1'b0;
      hits = ready[2] ? 1 : 0;
      watch(2, 8, lat);
      check("rstwait_ready", 32'(hits + lat), 32'd0);
      xact(2, 32'h40, 4'h0, 32'h0, r, lat);
      check("rstwait_data", r, 32'hCAFE_F00D);
      @(negedge clk);
      valid[2] = 1'b1;
      address  = 32'h40;
      wstrobe  = 4'hF;
      wdata    = 32'h5555_5555;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready[2] && lat < 50);
      reset_n  = 1'b0;
      valid[2] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      xact(2, 32'h40, 4'h0, 32'h0, r, lat);
      check("rstack_data", r, 32'hCAFE_F00D);
      @(negedge clk);
`ifdef VERMIRAM_STATS_EN
      check("d2_rc", rc[2], 32'd1);
      check("d2_wc", wc[2], 32'd0);
`endif
      xact(3, 32'h08, 4'hF, 32'h0BAD_CAFE, r, lat);
      check("ws0_lat", 32'(lat), 32'd1);
      @(negedge clk);
      valid[3] = 1'b1;
      address  = 32'h04;
      wstrobe  = 4'hF;
      wdata    = 32'h55AA_55AA;
      @(negedge clk);
      check("b2b_c1", {31'h0, ready[3]}, 32'h1);
      address = 32'h08;
      wstrobe = 4'h0;
      @(negedge clk);
      check("b2b_c2", {31'h0, ready[3]}, 32'h0);
      @(negedge clk);
      check("b2b_c3", {31'h0, ready[3]}, 32'h1);
      check("b2b_rd08", rdata[3], 32'h0BAD_CAFE);
      address = 32'h04;
      @(negedge clk);
      check("b2b_c4", {31'h0, ready[3]}, 32'h0);
      @(negedge clk);
      check("b2b_c5", {31'h0, ready[3]}, 32'h1);
      check("b2b_rd04", rdata[3], 32'h55AA_55AA);
      valid[3] = 1'b0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
